// File: rtl/lsu_pkg.sv
// Shared constants, request payload and decode helpers for the load/store unit.
package lsu_pkg;

  localparam int unsigned LSU_WIDTH = 32;
  localparam int unsigned LSU_LANES = 4;

  // funct3 access size/sign encodings
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Fields of the accepted request needed after the memory handshake
  typedef struct packed {
    logic       is_store;
    logic [2:0] funct3;
    logic [1:0] addr_lo;
  } lsu_req_t;

  // Misalignment or illegal size/sign for the requested access
  function automatic logic lsu_fault(input logic       is_store,
                                     input logic [2:0] f3,
                                     input logic [1:0] addr_lo);
    logic flt;
    case (f3)
      LSU_B:   flt = 1'b0;
      LSU_H:   flt = addr_lo[0];
      LSU_W:   flt = (addr_lo != 2'b00);
      LSU_BU:  flt = is_store;
      LSU_HU:  flt = is_store | addr_lo[0];
      default: flt = 1'b1;
    endcase
    return flt;
  endfunction

  // Byte-lane strobes for a store of the given size
  function automatic logic [LSU_LANES-1:0] lsu_wstrb(input logic [2:0] f3,
                                                     input logic [1:0] addr_lo);
    logic [LSU_LANES-1:0] strb;
    case (f3[1:0])
      2'b00:   strb = 4'b0001 << addr_lo;
      2'b01:   strb = 4'b0011 << {addr_lo[1], 1'b0};
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half/word lane of a read word and extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [LSU_WIDTH-1:0] i_mem_rdata,
  input  logic [1:0]           i_addr_lo,
  input  logic [2:0]           i_funct3,
  output logic [LSU_WIDTH-1:0] o_rdata
);

  logic [LSU_WIDTH-1:0] w_lane;

  // Shift the addressed lane down to bit 0, then extend per funct3
  always_comb begin
    w_lane  = i_mem_rdata >> {i_addr_lo, 3'b000};
    o_rdata = '0;
    case (i_funct3)
      LSU_B:   o_rdata = {{24{w_lane[7]}}, w_lane[7:0]};
      LSU_H:   o_rdata = {{16{w_lane[15]}}, w_lane[15:0]};
      LSU_W:   o_rdata = w_lane;
      LSU_BU:  o_rdata = {24'h0, w_lane[7:0]};
      LSU_HU:  o_rdata = {16'h0, w_lane[15:0]};
      default: o_rdata = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one data-memory transaction per accepted request.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned WIDTH = LSU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_store,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [WIDTH-1:0] rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_wstrb,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata
);

  logic [1:0]       r_state;
  lsu_req_t         r_req;
  logic             r_busy;
  logic             r_done;
  logic             r_fault;
  logic [WIDTH-1:0] r_rdata;
  logic             r_mem_req;
  logic             r_mem_we;
  logic [WIDTH-1:0] r_mem_addr;
  logic [3:0]       r_mem_wstrb;
  logic [WIDTH-1:0] r_mem_wdata;

  logic [1:0]       w_state_nxt;
  lsu_req_t         w_req_nxt;
  logic             w_fault_nxt;
  logic [WIDTH-1:0] w_rdata_nxt;
  logic             w_mem_we_nxt;
  logic [WIDTH-1:0] w_mem_addr_nxt;
  logic [3:0]       w_mem_wstrb_nxt;
  logic [WIDTH-1:0] w_mem_wdata_nxt;
  logic             w_req_fault;
  logic [WIDTH-1:0] w_load_data;

  lsu_load_align u_load_align (
    .i_mem_rdata (mem_rdata),
    .i_addr_lo   (r_req.addr_lo),
    .i_funct3    (r_req.funct3),
    .o_rdata     (w_load_data)
  );

  assign w_req_fault = lsu_fault(is_store, funct3, addr[1:0]);

  // Next-state and next-register decode; memory fields latch at accept and hold through REQ
  always_comb begin
    w_state_nxt     = r_state;
    w_req_nxt       = r_req;
    w_fault_nxt     = r_fault;
    w_rdata_nxt     = r_rdata;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wstrb_nxt = r_mem_wstrb;
    w_mem_wdata_nxt = r_mem_wdata;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_req_nxt.is_store = is_store;
          w_req_nxt.funct3   = funct3;
          w_req_nxt.addr_lo  = addr[1:0];
          w_fault_nxt        = w_req_fault;
          w_rdata_nxt        = '0;
          if (w_req_fault) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt     = ST_REQ;
            w_mem_we_nxt    = is_store;
            w_mem_addr_nxt  = {addr[WIDTH-1:2], 2'b00};
            w_mem_wstrb_nxt = is_store ? lsu_wstrb(funct3, addr[1:0]) : 4'b0000;
            case (funct3[1:0])
              2'b00:   w_mem_wdata_nxt = {4{wdata[7:0]}};
              2'b01:   w_mem_wdata_nxt = {2{wdata[15:0]}};
              default: w_mem_wdata_nxt = wdata;
            endcase
          end
        end
      end
      ST_REQ: begin
        if (mem_ready) begin
          w_state_nxt     = ST_DONE;
          w_rdata_nxt     = r_req.is_store ? '0 : w_load_data;
          w_mem_we_nxt    = 1'b0;
          w_mem_wstrb_nxt = 4'b0000;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers; status outputs follow the next state so they align with it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_req       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
      r_rdata     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wstrb <= 4'b0000;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req       <= w_req_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_done      <= (w_state_nxt == ST_DONE);
      r_fault     <= w_fault_nxt;
      r_rdata     <= w_rdata_nxt;
      r_mem_req   <= (w_state_nxt == ST_REQ);
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wstrb <= w_mem_wstrb_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign fault     = r_fault;
  assign rdata     = r_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wstrb = r_mem_wstrb;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for the load/store unit.
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  lsu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_store  (is_store),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; returns in the first cycle after acceptance
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    is_store = st;
    funct3   = f3;
    addr     = a;
    wdata    = wd;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Load with zero wait states: ready in cycle 1, done in cycle 2
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] exp_addr, input logic [31:0] word,
                         input logic [31:0] exp);
    issue(1'b0, f3, a, 32'h0);
    check({tag, ".mem_req"}, 32'(mem_req), 32'd1);
    check({tag, ".mem_addr"}, mem_addr, exp_addr);
    check({tag, ".wstrb"}, 32'(mem_wstrb), 32'h0);
    check({tag, ".done_c1"}, 32'(done), 32'd0);
    mem_ready = 1'b1;
    mem_rdata = word;
    tick();
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".rdata"}, rdata, exp);
    check({tag, ".fault"}, 32'(fault), 32'd0);
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    tick();
    check({tag, ".idle"}, 32'(busy), 32'd0);
    check({tag, ".rdata_hold"}, rdata, exp);
  endtask

  // Faulting request: done with fault in cycle 1 and no memory access
  task automatic do_fault(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a);
    issue(st, f3, a, 32'hFFFF_FFFF);
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".fault"}, 32'(fault), 32'd1);
    check({tag, ".mem_req"}, 32'(mem_req), 32'd0);
    check({tag, ".rdata"}, rdata, 32'h0);
    check({tag, ".busy"}, 32'(busy), 32'd1);
    tick();
    check({tag, ".done_end"}, 32'(done), 32'd0);
    check({tag, ".busy_end"}, 32'(busy), 32'd0);
    check({tag, ".mem_req_end"}, 32'(mem_req), 32'd0);
    check({tag, ".fault_hold"}, 32'(fault), 32'd1);
  endtask

  // Store with a given number of wait cycles before ready
  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int waits,
                          input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata);
    issue(1'b1, f3, a, wd);
    for (int i = 0; i <= waits; i++) begin
      check({tag, ".mem_req"}, 32'(mem_req), 32'd1);
      check({tag, ".mem_we"}, 32'(mem_we), 32'd1);
      check({tag, ".mem_addr"}, mem_addr, exp_addr);
      check({tag, ".wstrb"}, 32'(mem_wstrb), 32'(exp_strb));
      check({tag, ".wdata"}, mem_wdata, exp_wdata);
      check({tag, ".no_done"}, 32'(done), 32'd0);
      if (i == waits) mem_ready = 1'b1;
      tick();
    end
    mem_ready = 1'b0;
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".rdata"}, rdata, 32'h0);
    check({tag, ".fault"}, 32'(fault), 32'd0);
    check({tag, ".req_drop"}, 32'(mem_req), 32'd0);
    tick();
    check({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    is_store  = 1'b0;
    funct3    = 3'b000;
    addr      = 32'h0;
    wdata     = 32'h0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    tick();
    tick();
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.fault", 32'(fault), 32'd0);
    check("rst.rdata", rdata, 32'h0);
    check("rst.mem_req", 32'(mem_req), 32'd0);
    check("rst.mem_we", 32'(mem_we), 32'd0);
    check("rst.wstrb", 32'(mem_wstrb), 32'h0);
    rst_n = 1'b1;
    tick();

    // Stray ready while idle must not complete anything
    mem_ready = 1'b1;
    tick();
    check("idle_ready.done", 32'(done), 32'd0);
    check("idle_ready.busy", 32'(busy), 32'd0);
    mem_ready = 1'b0;

    do_load("lw", 3'b010, 32'h0000_0100, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_load("lb", 3'b000, 32'h0000_0103, 32'h0000_0100, 32'h80FF_FFFF, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h0000_0103, 32'h0000_0100, 32'h80FF_FFFF, 32'h0000_0080);
    do_load("lh", 3'b001, 32'h0000_0102, 32'h0000_0100, 32'h80FF_1234, 32'hFFFF_80FF);
    do_load("lhu", 3'b101, 32'h0000_0102, 32'h0000_0100, 32'h80FF_1234, 32'h0000_80FF);
    do_load("lb1", 3'b000, 32'h0000_0101, 32'h0000_0100, 32'h0000_7F00, 32'h0000_007F);

    do_store("sh", 3'b001, 32'h0000_0206, 32'h1234_ABCD, 3, 32'h0000_0204, 4'b1100, 32'hABCD_ABCD);
    do_store("sb", 3'b000, 32'h0000_0002, 32'h0000_00EF, 0, 32'h0000_0000, 4'b0100, 32'hEFEF_EFEF);
    do_store("sw", 3'b010, 32'h0000_0300, 32'hCAFE_1234, 1, 32'h0000_0300, 4'b1111, 32'hCAFE_1234);

    // Leave a nonzero rdata so the fault path must clear it
    do_load("lw_pre", 3'b010, 32'h0000_0010, 32'h0000_0010, 32'h5555_AAAA, 32'h5555_AAAA);
    do_fault("flt_lw", 1'b0, 3'b010, 32'h0000_0102);
    do_fault("flt_sh", 1'b1, 3'b001, 32'h0000_0101);
    do_fault("flt_f3", 1'b0, 3'b011, 32'h0000_0100);
    do_fault("flt_sbu", 1'b1, 3'b100, 32'h0000_0100);

    // start held through REQ and DONE is ignored
    issue(1'b0, 3'b010, 32'h0000_0040, 32'h0);
    is_store = 1'b1;
    addr     = 32'h0000_0080;
    start    = 1'b1;
    tick();
    check("ign.mem_addr", mem_addr, 32'h0000_0040);
    check("ign.mem_we", 32'(mem_we), 32'd0);
    check("ign.busy", 32'(busy), 32'd1);
    mem_ready = 1'b1;
    mem_rdata = 32'h1122_3344;
    tick();
    check("ign.done", 32'(done), 32'd1);
    check("ign.rdata", rdata, 32'h1122_3344);
    mem_ready = 1'b0;
    tick();
    check("ign.busy_after", 32'(busy), 32'd0);
    check("ign.req_after", 32'(mem_req), 32'd0);
    start = 1'b0;
    tick();
    check("ign.still_idle", 32'(busy), 32'd0);
    check("ign.no_done", 32'(done), 32'd0);

    // Reset abandons an outstanding request
    issue(1'b0, 3'b010, 32'h0000_0500, 32'h0);
    check("rstreq.mem_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    tick();
    check("rstreq.req_drop", 32'(mem_req), 32'd0);
    check("rstreq.busy", 32'(busy), 32'd0);
    check("rstreq.done", 32'(done), 32'd0);
    check("rstreq.rdata", rdata, 32'h0);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    tick();
    check("rstreq.no_done", 32'(done), 32'd0);
    mem_ready = 1'b0;
    do_load("rst_lw", 3'b010, 32'h0000_0104, 32'h0000_0104, 32'hCAFE_F00D, 32'hCAFE_F00D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit of the RV32I execute/memory boundary. Consumes the ALU's address result (`alu_out`, ADD mode) plus rs2 and funct3 from the datapath. Runs one data-memory transaction over a valid/ready handshake and returns sign- or zero-extended load data to the writeback mux. It stalls the core via `busy` while a transaction is outstanding.

## Interface
- `WIDTH`, 32, datapath width; only 32 supported (byte-lane logic is fixed at 4 lanes)
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  request from execute stage; sampled only in IDLE
- `is_store`  in  1  1 = store, 0 = load
- `funct3`  in  3  instruction bits [14:12]: access size/sign
- `addr`  in  WIDTH  effective byte address (ALU output)
- `wdata`  in  WIDTH  store data (rs2)
- `busy`  out  1  high whenever state is not IDLE
- `done`  out  1  one-cycle completion pulse
- `fault`  out  1  valid with `done`; misaligned or illegal funct3
- `rdata`  out  WIDTH  extended load result, valid with `done`
- `mem_req`  out  1  memory request valid
- `mem_we`  out  1  write enable
- `mem_addr`  out  WIDTH  word address, `{addr[31:2],2'b00}`
- `mem_wstrb`  out  4  byte-lane write strobes
- `mem_wdata`  out  WIDTH  lane-replicated store data
- `mem_ready`  in  1  memory accepts/completes the request this cycle
- `mem_rdata`  in  WIDTH  read word, valid when `mem_ready` is high on a load

## Operation
- States: IDLE, REQ, DONE.
- IDLE, `start`=1: latch `is_store`, `funct3`, `addr`, `wdata`. If fault, go to DONE with `fault`=1 and issue no memory access. Otherwise go to REQ.
- Fault conditions:
  - funct3 is 011/110/111, or a store with funct3[2]=1.
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]≠0.
- REQ: `mem_req`=1. `mem_we`, `mem_addr`, `mem_wstrb` and `mem_wdata` are driven from the latched values and held stable until `mem_ready`. On `mem_ready`=1, capture the formatted `rdata` and go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE. `rdata`/`fault` hold until the next `start` is accepted.
- Stores:
  - SB: strobe 0001<<addr[1:0], data {4{wdata[7:0]}}.
  - SH: strobe 0011<<{addr[1],1'b0}, data {2{wdata[15:0]}}.
  - SW: strobe 1111, data `wdata`.
  - `rdata` = 0.
- Loads: strobe 0000. Lane = `mem_rdata` >> (8·addr[1:0]).
  - LB/LH: sign-extend from bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: lane unmodified.
- On fault completion, `rdata` = 0.
- `start` while `busy`=1 is ignored. The execute stage must hold the instruction while `busy`.

## Timing
- Reset (`rst_n`=0 at an edge) forces state IDLE. All outputs are 0, including `rdata` and `fault`.
- Reset mid-REQ drops `mem_req` after that edge and produces no `done`. The memory must treat an abandoned request as cancelled.
- Latency from `start` accepted at edge 0:
  - `mem_req` is high from cycle 1.
  - `mem_ready` high in cycle k (k ≥ 1) gives `done` in cycle k+1.
  - Minimum is 2 cycles; a faulted request completes in cycle 1.
- `mem_ready` is ignored outside REQ. A `mem_ready` in cycle 1 with zero wait states is legal.
- `busy` is high in REQ and DONE. A new `start` is accepted in the first IDLE cycle after DONE, so back-to-back throughput is one access per 3 cycles minimum.
- All outputs are registered or decoded from registered state; there is no combinational path from `mem_ready`/`mem_rdata` to outputs.

## Structure
- Shared package `lsu_pkg`:
  - funct3 constants LSU_B=000, LSU_H=001, LSU_W=010, LSU_BU=100, LSU_HU=101.
  - State encoding IDLE/REQ/DONE.
- Sub-module `lsu_load_align`: combinational `mem_rdata`, addr[1:0], funct3 → extended `rdata`. It is reused by the future misaligned-access trap handler.

## Test plan
- LW, addr=0x100, `mem_rdata`=0xDEADBEEF, `mem_ready` on the first REQ cycle -> `mem_addr`=0x100, `mem_wstrb`=0, `done` 2 cycles after `start`, `rdata`=0xDEADBEEF, `fault`=0.
- LB at addr=0x103 with `mem_rdata`=0x80FF_FFFF, and LBU at the same address -> `rdata`=0xFFFFFF80 and 0x00000080 respectively.
- SH, addr=0x206, `wdata`=0x1234ABCD, `mem_ready` delayed 3 cycles -> `mem_addr`=0x204, `mem_wstrb`=1100, `mem_wdata`=0xABCDABCD stable across all wait cycles, `done` 1 cycle after `mem_ready`.
- LW at addr=0x102, then SH at 0x101, then funct3=011 -> each gives `done` in cycle 1 with `fault`=1, `mem_req` never asserted, `rdata`=0.
- `start` pulsed during REQ and DONE -> ignored; exactly one transaction.
- `rst_n`=0 while in REQ -> `mem_req`/`busy`/`done`=0 next cycle, and a fresh LW afterwards completes normally.
